// File: rtl/display_scan_controller.sv
// Four-digit multiplexed display scanner with tear-free double-buffered updates.
// Define LZ_BLANK_EN to blank leading zeros (digit 0 always lit).
module display_scan_controller #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        disp_en,
    input  logic        upd_valid,
    input  logic [15:0] upd_data,
    output logic        upd_ready,
    output logic [1:0]  s,
    output logic [3:0]  an,
    output logic [3:0]  digit,
    output logic        frame_done
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        OFF  = 2'd0,
        SYNC = 2'd1,
        SCAN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]  s_q, s_d;
    logic [15:0] active_q, active_d;
    logic [15:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic        tick;
    logic        hs;
    logic        xfer;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= OFF;
            cnt_q     <= '0;
            s_q       <= 2'd0;
            active_q  <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        tick    = (cnt_q == LAST);
        if (!disp_en) begin
            state_d = OFF;
            cnt_d   = '0;
            s_d     = 2'd0;
        end else begin
            unique case (state_q)
                OFF: begin
                    state_d = SYNC;
                    cnt_d   = '0;
                    s_d     = 2'd0;
                end
                SYNC: begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (tick) state_d = SCAN;
                end
                SCAN: begin
                    cnt_d = tick ? '0 : cnt_q + 1'b1;
                    if (tick) s_d = s_q + 2'd1;
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                    s_d     = 2'd0;
                end
            endcase
        end
    end

    assign frame_done = (state_q == SCAN) && tick && (s_q == 2'd3);

    // Handshake needs pending clear, transfer needs it set: never both at once.
    always_comb begin
        hs        = upd_valid && !pending_q;
        xfer      = pending_q && (frame_done || (state_q != SCAN));
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (hs) begin
            shadow_d  = upd_data;
            pending_d = 1'b1;
        end else if (xfer) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
    end

`ifdef LZ_BLANK_EN
    logic [3:0] lz;
    assign lz[0] = 1'b0;
    assign lz[1] = (active_q[15:4] == 12'h000);
    assign lz[2] = (active_q[15:8] == 8'h00);
    assign lz[3] = (active_q[15:12] == 4'h0);
`endif

    always_comb begin
        an = 4'b1111;
        if (state_q == SCAN) begin
            an = ~(4'b0001 << s_q);
`ifdef LZ_BLANK_EN
            if (lz[s_q]) an = 4'b1111;
`endif
        end
    end

    assign s         = s_q;
    assign digit     = active_q[{s_q, 2'b00} +: 4];
    assign upd_ready = !pending_q;

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized and directed bench for display_scan_controller (REFRESH_DIV = 4)
// against a cycle-age reference model.
module tb_display_scan_controller;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        disp_en = 1'b0;
    logic        upd_valid = 1'b0;
    logic [15:0] upd_data = 16'h0000;
    logic        upd_ready;
    logic [1:0]  s;
    logic [3:0]  an;
    logic [3:0]  digit;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    // Model: cycles elapsed since display was enabled, plus buffer contents.
    bit          m_on   = 1'b0;
    int          m_age  = 0;
    logic [15:0] m_act  = 16'h0;
    logic [15:0] m_sh   = 16'h0;
    bit          m_pend = 1'b0;

    display_scan_controller #(.REFRESH_DIV(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .disp_en   (disp_en),
        .upd_valid (upd_valid),
        .upd_data  (upd_data),
        .upd_ready (upd_ready),
        .s         (s),
        .an        (an),
        .digit     (digit),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit m_scan();
        return m_on && (m_age >= N);
    endfunction

    function automatic int m_slot();
        return m_scan() ? ((m_age - N) / N) % 4 : 0;
    endfunction

    function automatic bit m_fd();
        return m_scan() && (((m_age - N) % (4 * N)) == 4 * N - 1);
    endfunction

    function automatic logic [3:0] m_an();
        logic [3:0] a;
        int k;
        k = m_slot();
        a = 4'b1111;
        if (m_scan()) begin
            a = 4'b1111;
            a[k] = 1'b0;
`ifdef LZ_BLANK_EN
            if (k >= 1 && (m_act >> (4 * k)) == 16'h0) a = 4'b1111;
`endif
        end
        return a;
    endfunction

    task automatic step(input bit r, input bit en, input bit v,
                        input logic [15:0] d);
        bit fd;
        bit sc;
        @(negedge clk);
        fd = m_fd();
        sc = m_scan();
        chk("an", 32'(an), 32'(m_an()));
        chk("s", 32'(s), 32'(m_slot()));
        chk("digit", 32'(digit), 32'((m_act >> (4 * m_slot())) & 16'hF));
        chk("frame_done", 32'(frame_done), 32'(fd));
        chk("upd_ready", 32'(upd_ready), 32'(!m_pend));
        reset     = r;
        disp_en   = en;
        upd_valid = v;
        upd_data  = d;
        @(posedge clk);
        if (!r) begin
            m_on = 0; m_age = 0; m_act = 0; m_sh = 0; m_pend = 0;
        end else begin
            if (v && !m_pend) begin
                m_sh = d; m_pend = 1;
            end else if (m_pend && (fd || !sc)) begin
                m_act = m_sh; m_pend = 0;
            end
            if (!en) begin
                m_on = 0; m_age = 0;
            end else if (!m_on) begin
                m_on = 1; m_age = 0;
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1, 1, 0, 16'h0);
    endtask

    initial begin
        step(0, 0, 0, 16'h0);
        step(0, 0, 0, 16'h0);
        step(1, 0, 1, 16'h1234);
        step(1, 0, 0, 16'h0);
        run(40);
        // Wait for slot 1, then request a mid-frame update
        for (int i = 0; i < 40 && m_slot() != 1; i++) run(1);
        chk("reach_slot1", 32'(m_slot()), 32'd1);
        step(1, 1, 1, 16'h5678);
        for (int i = 0; i < 24; i++) step(1, 1, 1, 16'h9999);
        run(36);
        step(1, 1, 1, 16'hABCD);
        run(3);
        step(0, 1, 0, 16'h0);
        step(1, 1, 0, 16'h0);
        step(1, 1, 1, 16'h0007);
        run(40);
        step(1, 1, 1, 16'h0000);
        run(40);
        step(1, 1, 1, 16'h0050);
        run(40);
        step(1, 0, 0, 16'h0);
        step(1, 1, 1, 16'h0300);
        run(40);
        for (int i = 0; i < 3000; i++) begin
            bit r, en, v;
            r  = ($urandom_range(0, 299) != 0);
            en = ($urandom_range(0, 79) != 0);
            v  = ($urandom_range(0, 5) == 0);
            step(r, en, v, 16'($urandom) & (($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'h00FF));
        end
        run(20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
